// File: rtl/operand_pipe_unit.sv
// operand_pipe_unit: builds the ALU second operand N from RB or the instruction
// immediate (pass, sign-extended immediates, left immediate, fixed and SAR-driven
// shifts, field extract). Holds the Shift Amount Register. One or two pipeline
// stages, valid/ready on both sides, flushable.
`timescale 1ns/1ps

module operand_pipe_unit #(
    parameter int WIDTH  = 32,
    parameter int IMM_W  = 21,
    parameter int STAGES = 1,
    localparam int SA_W  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] rb,
    input  logic [IMM_W-1:0] imm,
    input  logic [3:0]       sel,
    input  logic             sar_we,
    input  logic [SA_W-1:0]  sar_wdata,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] n,
    output logic [SA_W-1:0]  sar
);

    // Elaboration guards: unsupported configurations must not build.
    if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
        $error("operand_pipe_unit: STAGES must be 1 or 2");
    end
    if (WIDTH < 16 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("operand_pipe_unit: WIDTH must be a power of 2 and >= 16");
    end
    if (IMM_W > WIDTH || IMM_W < 14 || IMM_W < 2 * SA_W) begin : g_bad_imm
        $error("operand_pipe_unit: IMM_W must cover imm[13:1] and both shift fields, and be <= WIDTH");
    end

    // Operation class carried from decode to the shift/mask step.
    typedef enum logic [2:0] {
        OP_PASS = 3'd0,
        OP_SRL  = 3'd1,
        OP_SRA  = 3'd2,
        OP_SLL  = 3'd3,
        OP_EXTU = 3'd4,
        OP_EXTS = 3'd5
    } op_kind_e;

    // Handshake: a request transfers on a cycle where in_valid && in_ready, a
    // result transfers where out_valid && out_ready. in_ready never depends on
    // in_valid; it is low during reset and flush and otherwise follows whether
    // stage 1 is empty or will move on this cycle, which chains combinationally
    // back from out_ready. While out_valid && !out_ready nothing in the pipe moves.

    logic [SA_W-1:0]  sar_q;
    logic [SA_W-1:0]  fld_p;
    logic [SA_W-1:0]  fld_c;
    logic [SA_W-1:0]  fix_amt;

    op_kind_e         dec_kind;
    logic [WIDTH-1:0] dec_opnd;
    logic [SA_W-1:0]  dec_amt;
    logic [SA_W-1:0]  dec_c;

    logic             s1_adv;
    logic             last_valid;
    logic [WIDTH-1:0] n_q;
    logic             accept;

    // Shift/extract fields; the fixed amount is WIDTH-1-p, wrapping modulo WIDTH.
    assign fld_p   = imm[2*SA_W-1:SA_W];
    assign fld_c   = imm[SA_W-1:0];
    assign fix_amt = SA_W'(WIDTH - 1) - fld_p;

    assign in_ready  = rst_n && !flush && s1_adv;
    assign accept    = in_valid && in_ready;
    assign out_valid = last_valid;
    assign n         = n_q;
    assign sar       = sar_q;

    // Shift/mask step shared by both pipeline depths.
    function automatic logic [WIDTH-1:0] exec_op(
        input op_kind_e         kind,
        input logic [WIDTH-1:0] v,
        input logic [SA_W-1:0]  amt,
        input logic [SA_W-1:0]  c
    );
        logic [WIDTH-1:0] sh;
        logic [WIDTH-1:0] mask;
        logic [WIDTH-1:0] ext;
        logic [SA_W-1:0]  sign_pos;
        sh       = v >> amt;
        // mask(len) with len = WIDTH-c is all-ones shifted right by c; c=0 keeps every bit.
        mask     = {WIDTH{1'b1}} >> c;
        ext      = sh & mask;
        sign_pos = SA_W'(WIDTH - 1) - c;
        case (kind)
            OP_PASS: exec_op = v;
            OP_SRL:  exec_op = sh;
            OP_SRA:  exec_op = $signed(v) >>> amt;
            OP_SLL:  exec_op = v << amt;
            OP_EXTU: exec_op = ext;
            OP_EXTS: exec_op = ext | (sh[sign_pos] ? ~mask : '0);
            default: exec_op = '0;
        endcase
    endfunction

    // Decode: choose operand, operation class and effective shift amount; SAR is sampled here.
    always_comb begin
        dec_kind = OP_PASS;
        dec_opnd = '0;
        dec_amt  = '0;
        dec_c    = '0;
        case (sel)
            4'd0: dec_opnd = rb;
            4'd1: dec_opnd = {{(WIDTH-11){imm[0]}}, imm[0], imm[10:1]};
            4'd2: dec_opnd = {{(WIDTH-14){imm[0]}}, imm[0], imm[13:1]};
            4'd3: dec_opnd = WIDTH'(imm) << (WIDTH - IMM_W);
            4'd4: begin dec_kind = OP_SRL;  dec_opnd = rb; dec_amt = fix_amt; end
            4'd5: begin dec_kind = OP_SRA;  dec_opnd = rb; dec_amt = fix_amt; end
            4'd6: begin dec_kind = OP_SLL;  dec_opnd = rb; dec_amt = fix_amt; end
            4'd7: dec_opnd = '0;
            4'd8: begin dec_kind = OP_SRL;  dec_opnd = rb; dec_amt = sar_q; end
            4'd9: begin dec_kind = OP_SRA;  dec_opnd = rb; dec_amt = sar_q; end
            4'd10: begin dec_kind = OP_SLL; dec_opnd = rb; dec_amt = sar_q; end
            4'd11: begin
                dec_kind = OP_EXTU;
                dec_opnd = rb;
                dec_amt  = fix_amt;
                dec_c    = fld_c;
            end
            4'd12: begin
                dec_kind = OP_EXTS;
                dec_opnd = rb;
                dec_amt  = fix_amt;
                dec_c    = fld_c;
            end
            default: dec_opnd = '0;
        endcase
    end

    // SAR: written on sar_we regardless of flush; the op accepted alongside saw the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sar_q <= '0;
        end else if (sar_we) begin
            sar_q <= sar_wdata;
        end
    end

    if (STAGES == 1) begin : g_one_stage
        logic s1_valid;

        assign s1_adv     = !s1_valid || out_ready;
        assign last_valid = s1_valid;

        // Single stage: decode and shift in one cycle; n is the stage register itself.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_valid <= 1'b0;
                n_q      <= '0;
            end else if (flush) begin
                s1_valid <= 1'b0;
            end else if (s1_adv) begin
                s1_valid <= accept;
                if (accept) begin
                    n_q <= exec_op(dec_kind, dec_opnd, dec_amt, dec_c);
                end
            end
        end
    end else begin : g_two_stage
        logic             s1_valid;
        op_kind_e         s1_kind;
        logic [WIDTH-1:0] s1_opnd;
        logic [SA_W-1:0]  s1_amt;
        logic [SA_W-1:0]  s1_c;
        logic             s2_valid;
        logic             s2_adv;

        assign s2_adv     = !s2_valid || out_ready;
        assign s1_adv     = !s1_valid || s2_adv;
        assign last_valid = s2_valid;

        // Stage 1: capture decoded class, operand and effective shift amount.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_valid <= 1'b0;
                s1_kind  <= OP_PASS;
                s1_opnd  <= '0;
                s1_amt   <= '0;
                s1_c     <= '0;
            end else if (flush) begin
                s1_valid <= 1'b0;
            end else if (s1_adv) begin
                s1_valid <= accept;
                if (accept) begin
                    s1_kind <= dec_kind;
                    s1_opnd <= dec_opnd;
                    s1_amt  <= dec_amt;
                    s1_c    <= dec_c;
                end
            end
        end

        // Stage 2: perform the shift/mask and present the result.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_valid <= 1'b0;
                n_q      <= '0;
            end else if (flush) begin
                s2_valid <= 1'b0;
            end else if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    n_q <= exec_op(s1_kind, s1_opnd, s1_amt, s1_c);
                end
            end
        end
    end

endmodule

// File: tb/tb_operand_pipe_unit.sv
// Bench for operand_pipe_unit: a one-stage and a two-stage instance run side by
// side on shared stimulus, each scored against a reference model.
`timescale 1ns/1ps

module tb_operand_pipe_unit;

  logic        clk;
  logic        rst_n;
  logic        iv [2];
  logic        ir [2];
  logic [31:0] rb;
  logic [20:0] imm;
  logic [3:0]  sel;
  logic        sar_we;
  logic [4:0]  sar_wdata;
  logic        flush;
  logic        ov [2];
  logic        out_ready;
  logic [31:0] nn [2];
  logic [4:0]  sr [2];

  int total;
  int bad;

  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [4:0]  model_sar;
  logic        acc_seen [2];
  logic        stall_prev [2];
  logic [31:0] n_prev [2];
  logic        flush_prev;
  logic        rand_bp;
  int          or_low_left;

  operand_pipe_unit #(.WIDTH(32), .IMM_W(21), .STAGES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .rb(rb), .imm(imm),
    .sel(sel), .sar_we(sar_we), .sar_wdata(sar_wdata), .flush(flush),
    .out_valid(ov[0]), .out_ready(out_ready), .n(nn[0]), .sar(sr[0])
  );

  operand_pipe_unit #(.WIDTH(32), .IMM_W(21), .STAGES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .rb(rb), .imm(imm),
    .sel(sel), .sar_we(sar_we), .sar_wdata(sar_wdata), .flush(flush),
    .out_valid(ov[1]), .out_ready(out_ready), .n(nn[1]), .sar(sr[1])
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model: operand value from the mode rules, using integer arithmetic.
  function automatic logic [31:0] ref_n(input logic [3:0] s, input logic [31:0] b,
                                        input logic [20:0] im, input logic [4:0] sa);
    int p, c, fa, len;
    longint sb, r;
    p  = int'(im[9:5]);
    c  = int'(im[4:0]);
    fa = 31 - p;
    sb = b[31] ? longint'(b) - (longint'(1) << 32) : longint'(b);
    r  = 0;
    case (s)
      4'd0:  r = longint'(b);
      4'd1:  r = longint'(im[10:1]) - (im[0] ? longint'(1024) : longint'(0));
      4'd2:  r = longint'(im[13:1]) - (im[0] ? longint'(8192) : longint'(0));
      4'd3:  r = longint'(im) * 2048;
      4'd4:  r = longint'(b) / (longint'(1) << fa);
      4'd5:  r = sb >>> fa;
      4'd6:  r = longint'(b) * (longint'(1) << fa);
      4'd8:  r = longint'(b) / (longint'(1) << sa);
      4'd9:  r = sb >>> sa;
      4'd10: r = longint'(b) * (longint'(1) << sa);
      4'd11, 4'd12: begin
        len = (c == 0) ? 32 : 32 - c;
        r = (longint'(b) / (longint'(1) << fa)) % (longint'(1) << len);
        if (s == 4'd12 && r >= (longint'(1) << (len - 1))) r = r - (longint'(1) << len);
      end
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  // scoreboard: sampled on the falling edge, away from the active edge
  task automatic score(input int k);
    logic [31:0] e;
    if (stall_prev[k] && !flush_prev) begin
      check(k == 0 ? "hold_valid_s1" : "hold_valid_s2", 32'(ov[k]), 32'd1);
      check(k == 0 ? "hold_n_s1" : "hold_n_s2", nn[k], n_prev[k]);
    end
    check(k == 0 ? "sar_s1" : "sar_s2", 32'(sr[k]), 32'(model_sar));
    if (ov[k] && out_ready) begin
      if ((k == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
        check(k == 0 ? "extra_out_s1" : "extra_out_s2", 32'd1, 32'd0);
      end else begin
        e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check(k == 0 ? "n_s1" : "n_s2", nn[k], e);
      end
    end
    if (flush) begin
      check(k == 0 ? "flush_ready_s1" : "flush_ready_s2", 32'(ir[k]), 32'd0);
      if (k == 0) exp_q0.delete(); else exp_q1.delete();
    end else if (iv[k] && ir[k]) begin
      if (k == 0) exp_q0.push_back(ref_n(sel, rb, imm, model_sar));
      else        exp_q1.push_back(ref_n(sel, rb, imm, model_sar));
      acc_seen[k] = 1'b1;
    end
    stall_prev[k] = ov[k] && !out_ready;
    n_prev[k] = nn[k];
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q0.delete();
      exp_q1.delete();
      model_sar = '0;
      stall_prev[0] = 1'b0;
      stall_prev[1] = 1'b0;
      flush_prev = 1'b0;
    end else begin
      score(0);
      score(1);
      if (sar_we) model_sar = sar_wdata;
      flush_prev = flush;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    sar_we = 1'b0;
    if (or_low_left > 0) begin
      or_low_left--;
      if (or_low_left == 0) out_ready = 1'b1;
    end
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [3:0] s, input logic [31:0] b, input logic [20:0] im,
                      input logic we, input logic [4:0] wd);
    int cyc;
    sel = s; rb = b; imm = im; sar_we = we; sar_wdata = wd;
    acc_seen[0] = 1'b0;
    acc_seen[1] = 1'b0;
    iv[0] = 1'b1;
    iv[1] = 1'b1;
    cyc = 0;
    while ((iv[0] || iv[1]) && cyc < 64) begin
      step();
      if (acc_seen[0]) iv[0] = 1'b0;
      if (acc_seen[1]) iv[1] = 1'b0;
      cyc++;
    end
    if (iv[0] || iv[1]) begin
      check("send_timeout", 32'd1, 32'd0);
      iv[0] = 1'b0;
      iv[1] = 1'b0;
    end
  endtask

  // Single op into an empty pipe with out_ready high: checks the latency of each depth.
  task automatic directed(input string tag, input logic [3:0] s, input logic [31:0] b,
                          input logic [20:0] im, input logic we, input logic [4:0] wd,
                          input logic [31:0] exp);
    send(s, b, im, we, wd);
    check({tag, "_v_s1"}, 32'(ov[0]), 32'd1);
    check({tag, "_n_s1"}, nn[0], exp);
    check({tag, "_early_s2"}, 32'(ov[1]), 32'd0);
    step();
    check({tag, "_v_s2"}, 32'(ov[1]), 32'd1);
    check({tag, "_n_s2"}, nn[1], exp);
    check({tag, "_gone_s1"}, 32'(ov[0]), 32'd0);
    step();
  endtask

  task automatic write_sar(input logic [4:0] v);
    sar_we = 1'b1;
    sar_wdata = v;
    step();
    check("sar_wr_s1", 32'(sr[0]), 32'(v));
    check("sar_wr_s2", 32'(sr[1]), 32'(v));
  endtask

  task automatic do_flush();
    flush = 1'b1;
    sar_we = ($urandom_range(0, 1) == 1);
    sar_wdata = 5'($urandom());
    step();
    flush = 1'b0;
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    rand_bp = 1'b0;
    out_ready = 1'b1;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && cyc < 40) begin
      step();
      cyc++;
    end
    check("drain_q_s1", 32'(exp_q0.size()), 32'd0);
    check("drain_q_s2", 32'(exp_q1.size()), 32'd0);
  endtask

  logic [31:0] n_before [2];

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; iv[0] = 1'b0; iv[1] = 1'b0;
    rb = '0; imm = '0; sel = '0; sar_we = 1'b0; sar_wdata = '0; flush = 1'b0;
    out_ready = 1'b1; rand_bp = 1'b0; or_low_left = 0;
    model_sar = '0; flush_prev = 1'b0;
    stall_prev[0] = 1'b0; stall_prev[1] = 1'b0;
    acc_seen[0] = 1'b0; acc_seen[1] = 1'b0;

    #2;
    for (int k = 0; k < 2; k++) begin
      check("rst_valid", 32'(ov[k]), 32'd0);
      check("rst_n_out", nn[k], 32'd0);
      check("rst_sar", 32'(sr[k]), 32'd0);
      check("rst_ready", 32'(ir[k]), 32'd0);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // pass / immediate modes
    directed("sext11", 4'd1, 32'h0, 21'h003, 1'b0, 5'd0, 32'hFFFFFC01);
    directed("leftimm", 4'd3, 32'h0, 21'h00001, 1'b0, 5'd0, 32'h00000800);
    directed("pass", 4'd0, 32'hDEADBEEF, 21'h0, 1'b0, 5'd0, 32'hDEADBEEF);
    directed("sext14", 4'd2, 32'h0, 21'h2001, 1'b0, 5'd0, 32'hFFFFF000);

    // fixed shifts, p=28
    directed("srl_fix", 4'd4, 32'h80000010, 21'(28 << 5), 1'b0, 5'd0, 32'h10000002);
    directed("sra_fix", 4'd5, 32'h80000010, 21'(28 << 5), 1'b0, 5'd0, 32'hF0000002);
    directed("sll_fix", 4'd6, 32'h80000010, 21'(28 << 5), 1'b0, 5'd0, 32'h00000080);

    // SAR-driven shifts, including a write in the same cycle as an acceptance
    write_sar(5'd4);
    directed("srl_sar", 4'd8, 32'hF000000F, 21'h0, 1'b0, 5'd0, 32'h0F000000);
    directed("sll_sar", 4'd10, 32'h0000000F, 21'h0, 1'b0, 5'd0, 32'h000000F0);
    directed("sar_same", 4'd8, 32'hF000000F, 21'h0, 1'b1, 5'd8, 32'h0F000000);
    directed("sar_next", 4'd8, 32'hF000000F, 21'h0, 1'b0, 5'd0, 32'h00F00000);

    // extract, p=15 c=24
    directed("extru", 4'd11, 32'h12345678, 21'((15 << 5) | 24), 1'b0, 5'd0, 32'h00000034);
    directed("extrs", 4'd12, 32'h12F45678, 21'((15 << 5) | 24), 1'b0, 5'd0, 32'hFFFFFFF4);
    directed("reserved", 4'd14, 32'h12F45678, 21'((15 << 5) | 24), 1'b0, 5'd0, 32'h0);
    directed("extru_c0", 4'd11, 32'hA5A5A5A5, 21'(31 << 5), 1'b0, 5'd0, 32'hA5A5A5A5);

    // backpressure: 8 back-to-back ops, out_ready low for 3 cycles mid-stream
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        out_ready = 1'b0;
        or_low_left = 3;
      end
      send(4'($urandom_range(0, 12)), $urandom(), 21'($urandom()), 1'b0, 5'd0);
    end
    drain();

    // flush with both pipes full; the same-cycle request must not be accepted
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sel = 4'd0; rb = $urandom(); iv[0] = 1'b1; iv[1] = 1'b1;
      step();
    end
    n_before[0] = nn[0];
    n_before[1] = nn[1];
    rb = 32'h0BAD0BAD;
    flush = 1'b1; sar_we = 1'b1; sar_wdata = 5'd7;
    step();
    flush = 1'b0; iv[0] = 1'b0; iv[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("flush_valid", 32'(ov[k]), 32'd0);
      check("flush_n_held", nn[k], n_before[k]);
      check("flush_sar", 32'(sr[k]), 32'd7);
    end
    out_ready = 1'b1;
    repeat (4) step();
    check("post_flush_idle_s1", 32'(ov[0]), 32'd0);
    check("post_flush_idle_s2", 32'(ov[1]), 32'd0);

    // randomized stream with random backpressure, SAR writes and flushes
    rand_bp = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 24) == 0) do_flush();
      send(4'($urandom_range(0, 15)), $urandom(), 21'($urandom()),
           ($urandom_range(0, 5) == 0), 5'($urandom()));
    end
    drain();

    // reset asserted mid-stream
    out_ready = 1'b0;
    send(4'd0, 32'h13572468, 21'h0, 1'b0, 5'd0);
    write_sar(5'd9);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("midrst_valid", 32'(ov[k]), 32'd0);
      check("midrst_n", nn[k], 32'd0);
      check("midrst_sar", 32'(sr[k]), 32'd0);
      check("midrst_ready", 32'(ir[k]), 32'd0);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    directed("after_rst", 4'd9, 32'h80000000, 21'h0, 1'b0, 5'd0, 32'h80000000);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
